// File: rtl/drum_pkg.sv
// Shared definitions for the DRUM approximate multiplier pipeline.
//   clog2    : ceiling log2 (minimum 1), used to size shift-amount fields
//   K_MIN    : smallest legal number of retained significant bits
//   W_MIN    : smallest legal operand width
//   W_MAX    : largest legal operand width
//   k_legal  : true when an (A_W, B_W, K) combination is supported
package drum_pkg;

    localparam int K_MIN = 3;
    localparam int W_MIN = 4;
    localparam int W_MAX = 64;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                res++;
                v = v >> 1;
            end
        end
        if (res == 0) res = 1;
        return res;
    endfunction

    function automatic bit k_legal(input int a_w, input int b_w, input int k);
        int w_small;
        w_small = (a_w < b_w) ? a_w : b_w;
        return (a_w >= W_MIN) && (a_w <= W_MAX) &&
               (b_w >= W_MIN) && (b_w <= W_MAX) &&
               (k >= K_MIN) && (k <= w_small);
    endfunction

endpackage

// File: rtl/drum_trunc.sv
// Combinational DRUM window select for one operand magnitude.
// Finds the leading one of mag and keeps the K bits starting there, with the
// lowest kept bit forced to 1 so the discarded tail is unbiased on average.
// Magnitudes below 2^K pass through unchanged with zero shift (exact).
//   mag : in  W bits   unsigned magnitude
//   t   : out K bits   truncated significand
//   s   : out clog2(W) left shift that restores the significand's weight
module drum_trunc
    import drum_pkg::*;
#(
    parameter int W = 16,
    parameter int K = 6
) (
    input  logic [W-1:0]        mag,
    output logic [K-1:0]        t,
    output logic [clog2(W)-1:0] s
);

    localparam int SW = clog2(W);

    logic [SW-1:0] lead;

    // Priority encode: the last set bit seen in an ascending scan is the MSB.
    always_comb begin
        lead = '0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) lead = SW'(i);
        end
    end

    always_comb begin
        t = mag[K-1:0];
        s = '0;
        if ({1'b0, lead} >= (SW+1)'(K)) begin
            s = lead - SW'(K - 1);
            t = K'(mag >> s) | K'(1);
        end
    end

endmodule

// File: rtl/drum_mult_pipe.sv
// Three-stage elastic DRUM approximate multiplier.
//   S1: operand magnitudes and result sign
//   S2: K-bit window select per operand and K x K product
//   S3: shift product back into place and apply the sign
// Each stage advances when its successor is empty or advancing, so a stalled
// consumer fills the pipe to three pairs before in_ready drops.
//   clk       : in   rising-edge clock
//   rst_n     : in   asynchronous active-low reset
//   in_valid  : in   operand pair presented
//   in_ready  : out  pair accepted this cycle
//   in_a      : in   A_W-bit operand a
//   in_b      : in   B_W-bit operand b
//   out_valid : out  result available
//   out_ready : in   consumer takes the result this cycle
//   out_r     : out  A_W+B_W-bit approximate product
module drum_mult_pipe
    import drum_pkg::*;
#(
    parameter int A_W    = 16,
    parameter int B_W    = 32,
    parameter int K      = 6,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     in_a,
    input  logic [B_W-1:0]     in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] out_r
);

    localparam int SHA_W = clog2(A_W);
    localparam int SHB_W = clog2(B_W);
    localparam int SH_W  = clog2(A_W + B_W);
    localparam int R_W   = A_W + B_W;
    localparam int P_W   = 2 * K;

    if (!k_legal(A_W, B_W, K)) begin : g_bad_param
        $error("drum_mult_pipe: unsupported A_W/B_W/K combination");
    end

    // in_ready must stay low until the first edge after reset release.
    logic             rst_done;

    logic             s1_valid, s2_valid, s3_valid;
    logic             s1_adv, s2_adv, s3_adv;
    logic             s1_load;

    logic             s1_sign;
    logic [A_W-1:0]   s1_mag_a;
    logic [B_W-1:0]   s1_mag_b;

    logic             s2_sign;
    logic [P_W-1:0]   s2_prod;
    logic [SH_W-1:0]  s2_shift;

    logic [R_W-1:0]   s3_r;

    logic             sign_in;
    logic [A_W-1:0]   mag_a;
    logic [B_W-1:0]   mag_b;
    logic [K-1:0]     ta, tb;
    logic [SHA_W-1:0] sa;
    logic [SHB_W-1:0] sb;
    logic [P_W-1:0]   prod;
    logic [SH_W-1:0]  shift_sum;
    logic [R_W-1:0]   mag_r;
    logic [R_W-1:0]   result;

    assign s3_adv   = s3_valid & out_ready;
    assign s2_adv   = s2_valid & (!s3_valid | s3_adv);
    assign s1_adv   = s1_valid & (!s2_valid | s2_adv);
    assign in_ready = rst_done & (!s1_valid | s1_adv);
    assign s1_load  = in_valid & in_ready;

    // Unary minus of the most-negative value wraps to itself, which read as
    // unsigned is exactly 2^(W-1).
    always_comb begin
        sign_in = 1'b0;
        mag_a   = in_a;
        mag_b   = in_b;
        if (SIGNED) begin
            sign_in = in_a[A_W-1] ^ in_b[B_W-1];
            if (in_a[A_W-1]) mag_a = -in_a;
            if (in_b[B_W-1]) mag_b = -in_b;
        end
    end

    drum_trunc #(.W(A_W), .K(K)) u_trunc_a (
        .mag (s1_mag_a),
        .t   (ta),
        .s   (sa)
    );

    drum_trunc #(.W(B_W), .K(K)) u_trunc_b (
        .mag (s1_mag_b),
        .t   (tb),
        .s   (sb)
    );

    assign prod      = {{K{1'b0}}, ta} * {{K{1'b0}}, tb};
    assign shift_sum = SH_W'(sa) + SH_W'(sb);

    // The shifted product never exceeds R_W bits; a zero product stays zero
    // after negation, so no separate zero handling is needed.
    always_comb begin
        mag_r  = R_W'(s2_prod) << s2_shift;
        result = s2_sign ? -mag_r : mag_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag_a <= '0;
            s1_mag_b <= '0;
            s2_sign  <= 1'b0;
            s2_prod  <= '0;
            s2_shift <= '0;
            s3_r     <= '0;
        end else begin
            rst_done <= 1'b1;

            if (in_ready) s1_valid <= in_valid;
            if (s1_load) begin
                s1_sign  <= sign_in;
                s1_mag_a <= mag_a;
                s1_mag_b <= mag_b;
            end

            if (!s2_valid | s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sign  <= s1_sign;
                    s2_prod  <= prod;
                    s2_shift <= shift_sum;
                end
            end

            if (!s3_valid | s3_adv) begin
                s3_valid <= s2_valid;
                if (s2_valid) s3_r <= result;
            end
        end
    end

    assign out_valid = s3_valid;
    assign out_r     = s3_r;

endmodule

// File: tb/tb_drum_mult_pipe.sv
// Scoreboard bench for drum_mult_pipe at default parameters (16 x 32, K=6).
module tb_drum_mult_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_r;

    int          n_cmp;
    int          n_err;
    logic [47:0] exp_q[$];
    bit          rand_ready;
    bit          hold_pend;
    logic [47:0] hold_val;

    drum_mult_pipe #(.A_W(16), .B_W(32), .K(6), .SIGNED(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Independent arithmetic model of the DRUM algorithm.
    function automatic void trunc6(input longint m, output longint t, output int s);
        int k;
        k = -1;
        for (int i = 0; i < 40; i++) if (m[i]) k = i;
        if (k >= 6) begin
            s = k - 5;
            t = (m >> s) | 64'd1;
        end else begin
            s = 0;
            t = m;
        end
    endfunction

    function automatic logic [47:0] ref_mul(input logic [15:0] a, input logic [31:0] b);
        longint ma, mb, ta, tb, u;
        int     sa, sb;
        bit     neg;
        neg = a[15] ^ b[31];
        ma  = a[15] ? (64'd65536 - longint'(a)) : longint'(a);
        mb  = b[31] ? (64'd4294967296 - longint'(b)) : longint'(b);
        trunc6(ma, ta, sa);
        trunc6(mb, tb, sb);
        u = (ta * tb) << (sa + sb);
        return neg ? 48'(-u) : 48'(u);
    endfunction

    // Called at a negedge; returns at the negedge after the input transfer.
    task automatic send(input logic [15:0] a, input logic [31:0] b, input logic [47:0] e);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops on every output transfer, and checks that a stalled
    // result is held unchanged on the following cycle.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) check("hold_stable", {15'd0, out_valid, out_r}, {15'd0, 1'b1, hold_val});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h, expected none", out_r);
                end else begin
                    check("result", {16'd0, out_r}, {16'd0, exp_q.pop_front()});
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = out_r;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] va[9];
    logic [31:0] vb[9];
    logic [47:0] ve[9];

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rand_ready = 1'b0;
        hold_pend  = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b1;

        va[0] = 16'd1000;       vb[0] = 32'd3;              ve[0] = 48'd3024;
        va[1] = 16'(-1000);     vb[1] = 32'd3;              ve[1] = 48'hFFFF_FFFF_F430;
        va[2] = 16'h8000;       vb[2] = 32'd1;              ve[2] = 48'hFFFF_FFFF_7C00;
        va[3] = 16'd0;          vb[3] = 32'(-5);            ve[3] = 48'd0;
        va[4] = 16'hFFFF;       vb[4] = 32'hFFFF_FFFF;      ve[4] = 48'd1;
        va[5] = 16'h7FFF;       vb[5] = 32'h7FFF_FFFF;      ve[5] = 48'h3E04_0000_0000;
        va[6] = 16'h8000;       vb[6] = 32'h8000_0000;      ve[6] = 48'h4410_0000_0000;
        va[7] = 16'd7;          vb[7] = 32'(-9);            ve[7] = 48'hFFFF_FFFF_FFC1;
        va[8] = 16'd63;         vb[8] = 32'd63;             ve[8] = 48'd3969;

        // Reset state
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_r", 64'(out_r), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        #10 rst_n = 1'b1;
        #1 check("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_release", 64'(in_ready), 64'd1);

        // Latency: 5*7 appears 3 cycles after the transfer cycle
        send(16'd5, 32'd7, 48'd35);
        check("lat_c1_valid", 64'(out_valid), 64'd0);
        check("lat_c1_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("lat_c2_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("lat_c3_valid", 64'(out_valid), 64'd1);
        check("lat_c3_r", 64'(out_r), 64'd35);
        check("lat_c3_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed vectors, back to back
        for (int i = 0; i < 9; i++) send(va[i], vb[i], ve[i]);
        repeat (5) @(negedge clk);

        // Backpressure: three pairs fill the pipe, then in_ready drops
        out_ready = 1'b0;
        send(16'd1, 32'd1, 48'd1);
        send(16'd2, 32'd2, 48'd4);
        send(16'd3, 32'd3, 48'd9);
        #1;
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head", 64'(out_r), 64'd1);
        @(negedge clk);
        fork
            begin
                send(16'd4, 32'd4, 48'd16);
                send(16'd5, 32'd5, 48'd25);
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with two pairs in flight
        send(16'd9, 32'd9, 48'd81);
        send(16'd10, 32'd10, 48'd100);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_r", 64'(out_r), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        #7 rst_n = 1'b1;
        #1 check("mid_rel_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check("mid_rel_in_ready", 64'(in_ready), 64'd1);
        repeat (6) @(negedge clk);
        #1 check("mid_rel_no_output", 64'(out_valid), 64'd0);

        // Random operands with random backpressure
        @(negedge clk);
        rand_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ra;
            logic [31:0] rb;
            ra = 16'($urandom);
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: ra = 16'h8000;
                1: ra = 16'd0;
                2: rb = 32'h8000_0000;
                3: ra = 16'($urandom_range(0, 63));
                4: rb = 32'($urandom_range(0, 63));
                default: ;
            endcase
            send(ra, rb, ref_mul(ra, rb));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        begin
            int guard;
            guard = 0;
            while (exp_q.size() != 0 && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
        end
        check("final_drain", 64'(exp_q.size()), 64'd0);
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
